// File: rtl/simple_cpu16.sv
// simple_cpu16: single-cycle 16-bit CPU with 256x16 instruction
// and data memories, an 8x16 register bank and an 8-bit PC.

module simple_cpu16_imem (
  input  logic [7:0]  addr_i,
  output logic [15:0] data_o
);

  // Zero-filled at power-up; 0x0000 decodes as NOP.
  logic [15:0] memory [0:255] = '{default: 16'h0000};

  assign data_o = memory[addr_i];

endmodule

module simple_cpu16_dmem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);

  logic [15:0] memory [0:255] = '{default: 16'h0000};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[addr_i];

endmodule

module simple_cpu16_regfile (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr_a_i,
  input  logic [2:0]  raddr_b_i,
  output logic [15:0] rdata_a_o,
  output logic [15:0] rdata_b_o
);

  logic [15:0] registers [0:7];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= 16'h0000;
      end
    end else if (we_i) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  // Reads see pre-edge contents.
  assign rdata_a_o = registers[raddr_a_i];
  assign rdata_b_o = registers[raddr_b_i];

endmodule

module simple_cpu16 (
  input logic clk,
  input logic reset
);

  localparam logic [4:0] OP_LI  = 5'b11000;
  localparam logic [4:0] OP_LM  = 5'b11001;
  localparam logic [4:0] OP_SM  = 5'b11010;
  localparam logic [4:0] OP_JMP = 5'b10101;

  localparam logic [3:0] FN_ADD = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0011;
  localparam logic [3:0] FN_OR  = 4'b0100;
  localparam logic [3:0] FN_XOR = 4'b0101;
  localparam logic [3:0] FN_NOT = 4'b0110;
  localparam logic [3:0] FN_MOV = 4'b0111;
  localparam logic [3:0] FN_SAR = 4'b1001;
  localparam logic [3:0] FN_SHR = 4'b1010;
  localparam logic [3:0] FN_SAL = 4'b1011;

  typedef struct packed {
    logic [4:0] op5;
    logic [2:0] r;
    logic [7:0] imm8;
    logic       alu;
    logic [3:0] fn;
    logic [2:0] rd;
    logic [2:0] rs;
  } dec_t;

  logic [7:0]  pc;
  logic [7:0]  pc_d;
  logic [15:0] instruction;
  dec_t        dec;

  logic        is_li;
  logic        is_lm;
  logic        is_sm;
  logic        is_jmp;

  logic [2:0]  ra_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  logic        dm_we;
  logic [15:0] dm_rdata;

  logic        alu_we;
  logic [15:0] alu_res;

  simple_cpu16_imem im (
    .addr_i (pc),
    .data_o (instruction)
  );

  simple_cpu16_regfile rb (
    .clk_i     (clk),
    .reset_i   (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ra_addr),
    .raddr_b_i (dec.rs),
    .rdata_a_o (ra_data),
    .rdata_b_o (rb_data)
  );

  simple_cpu16_dmem dm (
    .clk_i   (clk),
    .we_i    (dm_we),
    .addr_i  (dec.imm8),
    .wdata_i (ra_data),
    .rdata_o (dm_rdata)
  );

  always_comb begin
    dec.op5  = instruction[15:11];
    dec.r    = instruction[10:8];
    dec.imm8 = instruction[7:0];
    dec.alu  = (instruction[15:10] == 6'b000000);
    dec.fn   = instruction[9:6];
    dec.rd   = instruction[5:3];
    dec.rs   = instruction[2:0];
  end

  assign is_li  = (dec.op5 == OP_LI);
  assign is_lm  = (dec.op5 == OP_LM);
  assign is_sm  = (dec.op5 == OP_SM);
  assign is_jmp = (dec.op5 == OP_JMP);

  // Port A carries rd for ALU ops and r for memory/immediate ops.
  assign ra_addr  = dec.alu ? dec.rd : dec.r;
  assign rf_waddr = ra_addr;

  always_comb begin
    alu_we  = 1'b1;
    alu_res = ra_data;
    unique case (dec.fn)
      FN_ADD:  alu_res = ra_data + rb_data;
      FN_AND:  alu_res = ra_data & rb_data;
      FN_SUB:  alu_res = ra_data - rb_data;
      FN_OR:   alu_res = ra_data | rb_data;
      FN_XOR:  alu_res = ra_data ^ rb_data;
      FN_NOT:  alu_res = ~ra_data;
      FN_MOV:  alu_res = rb_data;
      FN_SAR:  alu_res = 16'($signed(ra_data) >>> dec.rs);
      FN_SHR:  alu_res = ra_data >> dec.rs;
      FN_SAL:  alu_res = ra_data << dec.rs;
      default: alu_we  = 1'b0;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    dm_we    = 1'b0;
    pc_d     = pc + 8'd1;
    unique case (1'b1)
      is_li: begin
        rf_we    = 1'b1;
        rf_wdata = {8'h00, dec.imm8};
      end
      is_lm: begin
        rf_we    = 1'b1;
        rf_wdata = dm_rdata;
      end
      is_sm:   dm_we = ~reset;
      is_jmp:  pc_d  = dec.imm8;
      dec.alu: rf_we = alu_we;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 8'h00;
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: tb/tb_simple_cpu16.sv
// Table-driven bench for simple_cpu16 with a scoreboard queue
// of expected pc / register / memory state per executed cycle.

module tb_simple_cpu16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  simple_cpu16 dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    logic [15:0] instr;
    logic        ld;
    logic [7:0]  pc;
    logic        mem;
    logic [7:0]  idx;
    logic [15:0] val;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic [15:0] instr,
    input logic        ld,
    input logic [7:0]  pc,
    input logic        mem,
    input logic [7:0]  idx,
    input logic [15:0] val
  );
    vec_t v;
    v.instr = instr;
    v.ld    = ld;
    v.pc    = pc;
    v.mem   = mem;
    v.idx   = idx;
    v.val   = val;
    return v;
  endfunction

  function automatic logic [15:0] alu(
    input logic [3:0] f,
    input logic [2:0] d,
    input logic [2:0] s
  );
    return {6'b000000, f, d, s};
  endfunction

  task automatic check(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_table();
    int a = 0;
    for (int i = 0; i < 256; i++) dut.im.memory[i] = 16'h0000;
    foreach (tbl[i]) begin
      if (tbl[i].ld) begin
        dut.im.memory[a] = tbl[i].instr;
        a++;
      end
    end
  endtask

  task automatic run_table(input string tag);
    vec_t e;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d] pc", tag, i), {8'h00, dut.pc}, {8'h00, e.pc});
      if (e.mem) begin
        check($sformatf("%s[%0d] dm[%0d]", tag, i, e.idx),
              dut.dm.memory[e.idx], e.val);
      end else begin
        check($sformatf("%s[%0d] R%0d", tag, i, e.idx),
              dut.rb.registers[e.idx[2:0]], e.val);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset pc", {8'h00, dut.pc}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("reset R%0d", i), dut.rb.registers[i], 16'h0000);
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit xseen;

    tbl = '{};
    tbl.push_back(mk(16'hC001, 1, 8'd1,  0, 0, 16'h0001));
    tbl.push_back(mk(16'hC102, 1, 8'd2,  0, 1, 16'h0002));
    tbl.push_back(mk(16'hC204, 1, 8'd3,  0, 2, 16'h0004));
    tbl.push_back(mk(16'hC408, 1, 8'd4,  0, 4, 16'h0008));
    tbl.push_back(mk(16'h0041, 1, 8'd5,  0, 0, 16'h0003));
    tbl.push_back(mk(16'h00D1, 1, 8'd6,  0, 2, 16'h0002));
    tbl.push_back(mk(16'h00CC, 1, 8'd7,  0, 1, 16'hFFFA));
    tbl.push_back(mk(16'h0081, 1, 8'd8,  0, 0, 16'h0002));
    tbl.push_back(mk(16'h0251, 1, 8'd9,  0, 2, 16'h0001));
    tbl.push_back(mk(16'h02C1, 1, 8'd10, 0, 0, 16'h0004));
    tbl.push_back(mk(16'hD203, 1, 8'd11, 1, 3, 16'h0001));
    tbl.push_back(mk(16'hCB03, 1, 8'd12, 0, 3, 16'h0001));
    tbl.push_back(mk(16'hA805, 1, 8'd5,  0, 0, 16'h0004));
    tbl.push_back(mk(16'h00D1, 0, 8'd6,  0, 2, 16'h0007));
    tbl.push_back(mk(16'h00CC, 0, 8'd7,  0, 1, 16'hFFF2));
    tbl.push_back(mk(16'h0081, 0, 8'd8,  0, 0, 16'h0000));
    load_table();
    do_reset();
    run_table("prog1");

    // Shifts, logic ops, undefined encodings, high memory address.
    tbl = '{};
    tbl.push_back(mk(16'hC580,                 1, 8'd1,  0, 5, 16'h0080));
    tbl.push_back(mk(alu(4'b1011, 3'd5, 3'd7), 1, 8'd2,  0, 5, 16'h4000));
    tbl.push_back(mk(alu(4'b1011, 3'd5, 3'd1), 1, 8'd3,  0, 5, 16'h8000));
    tbl.push_back(mk(alu(4'b1001, 3'd5, 3'd3), 1, 8'd4,  0, 5, 16'hF000));
    tbl.push_back(mk(alu(4'b0111, 3'd6, 3'd5), 1, 8'd5,  0, 6, 16'hF000));
    tbl.push_back(mk(alu(4'b1010, 3'd5, 3'd4), 1, 8'd6,  0, 5, 16'h0F00));
    tbl.push_back(mk(alu(4'b0110, 3'd6, 3'd0), 1, 8'd7,  0, 6, 16'h0FFF));
    tbl.push_back(mk(alu(4'b0101, 3'd6, 3'd5), 1, 8'd8,  0, 6, 16'h00FF));
    tbl.push_back(mk(alu(4'b0100, 3'd6, 3'd5), 1, 8'd9,  0, 6, 16'h0FFF));
    tbl.push_back(mk(alu(4'b1000, 3'd6, 3'd5), 1, 8'd10, 0, 6, 16'h0FFF));
    tbl.push_back(mk(16'hFFFF,                 1, 8'd11, 0, 5, 16'h0F00));
    tbl.push_back(mk(16'hD6FF,                 1, 8'd12, 1, 255, 16'h0FFF));
    tbl.push_back(mk(16'hCFFF,                 1, 8'd13, 0, 7, 16'h0FFF));
    tbl.push_back(mk(alu(4'b0000, 3'd7, 3'd7), 1, 8'd14, 0, 7, 16'h0FFF));
    load_table();
    do_reset();
    check("dm[3] kept over reset", dut.dm.memory[3], 16'h0001);
    run_table("prog2");

    // Free-run through unprogrammed NOPs up to the wrap point.
    xseen = 1'b0;
    for (int n = 0; n < 300 && dut.pc != 8'hFF; n++) begin
      @(posedge clk);
      #1;
      if ($isunknown(dut.pc)) xseen = 1'b1;
      for (int r = 0; r < 8; r++) begin
        if ($isunknown(dut.rb.registers[r])) xseen = 1'b1;
      end
    end
    check("pc reaches FF", {8'h00, dut.pc}, 16'h00FF);
    check("no X on pc/regs", {15'h0, xseen}, 16'h0000);
    check("R5 after NOP run", dut.rb.registers[5], 16'h0F00);
    check("R6 after NOP run", dut.rb.registers[6], 16'h0FFF);
    @(posedge clk);
    #1;
    check("pc wraps to 00", {8'h00, dut.pc}, 16'h0000);
    check("R7 after wrap", dut.rb.registers[7], 16'h0FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
